// File: rtl/port_ecc_batch_ctrl_if.sv
// rtl/port_ecc_batch_ctrl_if.sv - transfer, buffer-write and batch handshake signals of the ECC batch controller
interface port_ecc_batch_ctrl_if;
  logic        xfer_data_vld;
  logic [15:0] xfer_data;
  logic        end_of_packet;
  logic        xfer_stall;
  logic        buf_wr_en;
  logic [2:0]  buf_wr_idx;
  logic [15:0] buf_wr_data;
  logic        batch_vld;
  logic        batch_rdy;
  logic [3:0]  batch_words;
  logic        batch_last;
  logic [5:0]  batch_idx;
  logic        overrun_err;

  // Front end / downstream side: drives words and batch_rdy.
  modport master (
    output xfer_data_vld, xfer_data, end_of_packet, batch_rdy,
    input  xfer_stall, buf_wr_en, buf_wr_idx, buf_wr_data,
    input  batch_vld, batch_words, batch_last, batch_idx, overrun_err
  );

  // Controller side.
  modport slave (
    input  xfer_data_vld, xfer_data, end_of_packet, batch_rdy,
    output xfer_stall, buf_wr_en, buf_wr_idx, buf_wr_data,
    output batch_vld, batch_words, batch_last, batch_idx, overrun_err
  );
endinterface

// File: rtl/port_ecc_batch_ctrl.sv
// rtl/port_ecc_batch_ctrl.sv - 8-slot ECC encoder buffer batch sequencer; ECC_ZERO_PAD_EN enables zero padding of short batches
module port_ecc_batch_ctrl (
  input  logic                clk,
  input  logic                rst_n,
  port_ecc_batch_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_PAD  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic [1:0] state;
  logic [2:0] wr_ptr;
  logic       accept;
  logic       close;

  // xfer_stall is raised on the edge that enters PAD/HOLD, so any word seen
  // while it is low can only arrive in IDLE or FILL.
  assign accept = bus.xfer_data_vld && !bus.xfer_stall &&
                  ((state == ST_IDLE) || (state == ST_FILL));
  assign close  = accept && ((wr_ptr == 3'd7) || bus.end_of_packet);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      wr_ptr          <= 3'd0;
      bus.xfer_stall  <= 1'b0;
      bus.buf_wr_en   <= 1'b0;
      bus.buf_wr_idx  <= 3'd0;
      bus.buf_wr_data <= 16'h0000;
      bus.batch_vld   <= 1'b0;
      bus.batch_words <= 4'd0;
      bus.batch_last  <= 1'b0;
      bus.batch_idx   <= 6'd0;
      bus.overrun_err <= 1'b0;
    end else begin
      bus.buf_wr_en <= 1'b0;
      if (bus.xfer_data_vld && bus.xfer_stall) begin
        bus.overrun_err <= 1'b1;
      end

      case (state)
        ST_IDLE, ST_FILL: begin
          if (accept) begin
            bus.buf_wr_en   <= 1'b1;
            bus.buf_wr_idx  <= wr_ptr;
            bus.buf_wr_data <= bus.xfer_data;
            wr_ptr          <= wr_ptr + 3'd1;
            state           <= ST_FILL;
            if (close) begin
              bus.batch_words <= {1'b0, wr_ptr} + 4'd1;
              bus.batch_last  <= bus.end_of_packet;
              bus.xfer_stall  <= 1'b1;
`ifdef ECC_ZERO_PAD_EN
              state <= (bus.end_of_packet && (wr_ptr != 3'd7)) ? ST_PAD : ST_HOLD;
`else
              state <= ST_HOLD;
`endif
            end
          end
        end

        ST_PAD: begin
`ifdef ECC_ZERO_PAD_EN
          bus.buf_wr_en   <= 1'b1;
          bus.buf_wr_idx  <= wr_ptr;
          bus.buf_wr_data <= 16'h0000;
          wr_ptr          <= wr_ptr + 3'd1;
          if (wr_ptr == 3'd7) begin
            state <= ST_HOLD;
          end
`else
          state <= ST_HOLD;
`endif
        end

        ST_HOLD: begin
          // batch_vld rises one cycle after HOLD entry so the last buffer write has landed.
          if (!bus.batch_vld) begin
            bus.batch_vld <= 1'b1;
          end else if (bus.batch_rdy) begin
            bus.batch_vld  <= 1'b0;
            bus.xfer_stall <= 1'b0;
            wr_ptr         <= 3'd0;
            if (bus.batch_last) begin
              bus.batch_idx <= 6'd0;
              state         <= ST_IDLE;
            end else begin
              bus.batch_idx <= bus.batch_idx + 6'd1;
              state         <= ST_FILL;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_port_ecc_batch_ctrl.sv
// tb/tb_port_ecc_batch_ctrl.sv - directed self-checking bench for port_ecc_batch_ctrl
module tb_port_ecc_batch_ctrl;
  logic clk;
  logic rst_n;
  int   tests;
  int   errors;

  port_ecc_batch_ctrl_if bus ();

  port_ecc_batch_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

`ifdef ECC_ZERO_PAD_EN
  localparam int PAD_ON = 1;
`else
  localparam int PAD_ON = 0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [15:0] d, input logic eop, input logic [2:0] exp_idx);
    bus.xfer_data_vld = 1'b1;
    bus.xfer_data     = d;
    bus.end_of_packet = eop;
    step();
    bus.xfer_data_vld = 1'b0;
    bus.end_of_packet = 1'b0;
    check("wr_en", bus.buf_wr_en, 1);
    check("wr_idx", bus.buf_wr_idx, exp_idx);
    check("wr_data", bus.buf_wr_data, d);
  endtask

  task automatic wait_batch(input int exp_cyc);
    int cyc;
    cyc = 0;
    while (!bus.batch_vld && cyc < 40) begin
      step();
      cyc++;
    end
    check("batch_vld_seen", bus.batch_vld, 1);
    check("batch_latency", cyc, exp_cyc);
  endtask

  task automatic accept_batch();
    bus.batch_rdy = 1'b1;
    step();
    bus.batch_rdy = 1'b0;
    check("vld_after_rdy", bus.batch_vld, 0);
    check("stall_after_rdy", bus.xfer_stall, 0);
  endtask

  initial begin
    tests = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.xfer_data_vld = 1'b0;
    bus.xfer_data     = 16'h0000;
    bus.end_of_packet = 1'b0;
    bus.batch_rdy     = 1'b0;
    step();
    step();
    check("rst_stall", bus.xfer_stall, 0);
    check("rst_wr_en", bus.buf_wr_en, 0);
    check("rst_wr_idx", bus.buf_wr_idx, 0);
    check("rst_wr_data", bus.buf_wr_data, 0);
    check("rst_vld", bus.batch_vld, 0);
    check("rst_words", bus.batch_words, 0);
    check("rst_last", bus.batch_last, 0);
    check("rst_idx", bus.batch_idx, 0);
    check("rst_ovr", bus.overrun_err, 0);
    rst_n = 1'b1;
    step();

    // 8-word packet with batch_rdy tied high.
    bus.batch_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_word(16'(i + 1), (i == 7), 3'(i));
      check("t1_stall", bus.xfer_stall, (i == 7));
      check("t1_vld_early", bus.batch_vld, 0);
    end
    step();
    check("t1_vld", bus.batch_vld, 1);
    check("t1_words", bus.batch_words, 8);
    check("t1_last", bus.batch_last, 1);
    check("t1_idx", bus.batch_idx, 0);
    step();
    check("t1_vld_drop", bus.batch_vld, 0);
    check("t1_stall_drop", bus.xfer_stall, 0);
    bus.batch_rdy = 1'b0;

    // 3-word packet, short batch.
    for (int i = 0; i < 3; i++) begin
      send_word(16'h00a0 + 16'(i), (i == 2), 3'(i));
    end
    check("t2_stall", bus.xfer_stall, 1);
    check("t2_words", bus.batch_words, 3);
`ifdef ECC_ZERO_PAD_EN
    for (int s = 3; s < 8; s++) begin
      step();
      check("t2_pad_en", bus.buf_wr_en, 1);
      check("t2_pad_idx", bus.buf_wr_idx, s);
      check("t2_pad_data", bus.buf_wr_data, 0);
      check("t2_pad_vld", bus.batch_vld, 0);
    end
    wait_batch(1);
`else
    wait_batch(1 + 5 * PAD_ON);
`endif
    check("t2_last", bus.batch_last, 1);
    check("t2_idx", bus.batch_idx, 0);
    accept_batch();

    // 20-word packet, 4 cycles of back-pressure per batch, overrun in batch 0.
    for (int b = 0; b < 3; b++) begin
      int n;
      n = (b < 2) ? 8 : 4;
      for (int i = 0; i < n; i++) begin
        send_word(16'h1000 + 16'(b * 8 + i), (b == 2 && i == n - 1), 3'(i));
      end
      wait_batch((b < 2) ? 1 : 1 + 4 * PAD_ON);
      check("t3_idx", bus.batch_idx, b);
      check("t3_words", bus.batch_words, n);
      check("t3_last", bus.batch_last, (b == 2));
      for (int h = 0; h < 4; h++) begin
        check("t3_hold_stall", bus.xfer_stall, 1);
        check("t3_hold_vld", bus.batch_vld, 1);
        if (b == 0 && h == 1) begin
          bus.xfer_data_vld = 1'b1;
          bus.xfer_data     = 16'hdead;
          bus.end_of_packet = 1'b1;
        end
        step();
        if (b == 0 && h == 1) begin
          bus.xfer_data_vld = 1'b0;
          bus.end_of_packet = 1'b0;
          check("t3_ovr", bus.overrun_err, 1);
          check("t3_ovr_wr_en", bus.buf_wr_en, 0);
          check("t3_ovr_words", bus.batch_words, 8);
          check("t3_ovr_last", bus.batch_last, 0);
        end
      end
      accept_batch();
    end
    check("t3_ovr_sticky", bus.overrun_err, 1);
    check("t3_idx_reset", bus.batch_idx, 0);

    // Reset while batch 1 is held.
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 8; i++) begin
        send_word(16'h2000 + 16'(i), 1'b0, 3'(i));
      end
      wait_batch(1);
      if (b == 0) accept_batch();
    end
    check("t4_idx_before", bus.batch_idx, 1);
    rst_n = 1'b0;
    #1;
    check("t4_vld", bus.batch_vld, 0);
    check("t4_stall", bus.xfer_stall, 0);
    check("t4_idx", bus.batch_idx, 0);
    check("t4_words", bus.batch_words, 0);
    check("t4_ovr", bus.overrun_err, 0);
    check("t4_wr_idx", bus.buf_wr_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    send_word(16'h3000, 1'b0, 3'd0);
    send_word(16'h3001, 1'b1, 3'd1);
    wait_batch(1 + 6 * PAD_ON);
    check("t4_new_idx", bus.batch_idx, 0);
    check("t4_new_words", bus.batch_words, 2);
    check("t4_new_last", bus.batch_last, 1);
    accept_batch();

    // end_of_packet without a valid word is ignored.
    bus.end_of_packet = 1'b1;
    step();
    step();
    bus.end_of_packet = 1'b0;
    check("t5_wr_en", bus.buf_wr_en, 0);
    check("t5_stall", bus.xfer_stall, 0);
    check("t5_vld", bus.batch_vld, 0);
    send_word(16'h4000, 1'b1, 3'd0);
    wait_batch(1 + 7 * PAD_ON);
    check("t5_words", bus.batch_words, 1);
    accept_batch();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end
endmodule
